// File: rtl/data_collect_sched_pkg.sv
// -----------------------------------------------------------------------------
// data_collect_sched_pkg
//
// Shared definitions for the data collection sequencer:
//   - sequencer state encodings (DCOL_IDLE .. DCOL_DONE)
//   - RAM word tags (DCOL_TAG_CMD / DCOL_TAG_CMDH / DCOL_TAG_FB)
//   - field widths of the 32-bit buffer word
//   - dcol_pack(): builds the buffer word from a tag and a {ts, chan, data}
//     payload
//
// Buffer word layout: {tag[1:0], ts[9:0], chan[3:0], data[15:0]}
// -----------------------------------------------------------------------------
package data_collect_sched_pkg;

    localparam int DCOL_ADDR_W    = 10;
    localparam int DCOL_DECIM_W   = 8;
    localparam int DCOL_TS_W      = 10;
    localparam int DCOL_CHAN_W    = 4;
    localparam int DCOL_DATA_W    = 16;
    localparam int DCOL_TAG_W     = 2;
    localparam int DCOL_PAYLOAD_W = DCOL_TS_W + DCOL_CHAN_W + DCOL_DATA_W;
    localparam int DCOL_WORD_W    = DCOL_TAG_W + DCOL_PAYLOAD_W;

    // Channel selected after reset, before any arm.
    localparam logic [DCOL_CHAN_W-1:0] DCOL_RESET_CHAN = 4'd1;

    typedef enum logic [1:0] {
        DCOL_IDLE  = 2'd0,
        DCOL_ARMED = 2'd1,
        DCOL_RUN   = 2'd2,
        DCOL_DONE  = 2'd3
    } dcol_state_e;

    typedef enum logic [DCOL_TAG_W-1:0] {
        DCOL_TAG_NONE = 2'b00,
        DCOL_TAG_CMD  = 2'b01,   // command written in the cycle it arrived
        DCOL_TAG_CMDH = 2'b10,   // command written from the hold register
        DCOL_TAG_FB   = 2'b11    // feedback sample
    } dcol_tag_e;

    function automatic logic [DCOL_WORD_W-1:0] dcol_pack(
        input dcol_tag_e                   tag,
        input logic [DCOL_PAYLOAD_W-1:0]   payload
    );
        logic [DCOL_TAG_W-1:0] tag_bits;
        tag_bits = tag;
        return {tag_bits, payload};
    endfunction

endpackage

// File: rtl/data_collect_sched_arb.sv
// -----------------------------------------------------------------------------
// dcol_arb
//
// Two-source fixed-priority write arbiter for the collection RAM, with a
// one-entry command hold register.
//
// Priority per cycle: held command > feedback > new command.
//   - A new command that loses to feedback is parked in the hold register.
//   - A new command arriving while the hold register is occupied is dropped
//     and flagged on o_overrun (the held command keeps its slot).
//   - Feedback is never parked; feedback that loses to the held command is
//     simply lost (the feedback source is slow enough for this to be rare).
//
// The grant is combinational; the caller registers it into the RAM port.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_flush             empty the hold register at the next edge
//   i_cmd_valid         qualified command sample this cycle
//   i_cmd_payload       {ts, chan, data} of the command
//   i_fb_valid          qualified (decimated) feedback sample this cycle
//   i_fb_payload        {ts, chan, data} of the feedback sample
//   o_wr_valid          a word is granted this cycle
//   o_wr_word           tagged 32-bit word to write
//   o_overrun           pulse: a command was dropped this cycle
// -----------------------------------------------------------------------------
module dcol_arb
    import data_collect_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_flush,
    input  logic                      i_cmd_valid,
    input  logic [DCOL_PAYLOAD_W-1:0] i_cmd_payload,
    input  logic                      i_fb_valid,
    input  logic [DCOL_PAYLOAD_W-1:0] i_fb_payload,
    output logic                      o_wr_valid,
    output logic [DCOL_WORD_W-1:0]    o_wr_word,
    output logic                      o_overrun
);

    logic                      r_hold_valid;
    logic [DCOL_PAYLOAD_W-1:0] r_hold_payload;
    logic                      w_hold_valid_next;
    logic [DCOL_PAYLOAD_W-1:0] w_hold_payload_next;

    always_comb begin
        o_wr_valid          = 1'b0;
        o_wr_word           = '0;
        o_overrun           = 1'b0;
        w_hold_valid_next   = r_hold_valid;
        w_hold_payload_next = r_hold_payload;

        if (r_hold_valid) begin
            // Held command owns the slot. It is still unserved during this
            // cycle, so a new command has nowhere to go and is dropped.
            o_wr_valid        = 1'b1;
            o_wr_word         = dcol_pack(DCOL_TAG_CMDH, r_hold_payload);
            w_hold_valid_next = 1'b0;
            o_overrun         = i_cmd_valid;
        end else if (i_fb_valid) begin
            o_wr_valid = 1'b1;
            o_wr_word  = dcol_pack(DCOL_TAG_FB, i_fb_payload);
            if (i_cmd_valid) begin
                w_hold_valid_next   = 1'b1;
                w_hold_payload_next = i_cmd_payload;
            end
        end else if (i_cmd_valid) begin
            o_wr_valid = 1'b1;
            o_wr_word  = dcol_pack(DCOL_TAG_CMD, i_cmd_payload);
        end

        if (i_flush) begin
            w_hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid   <= 1'b0;
            r_hold_payload <= '0;
        end else begin
            r_hold_valid   <= w_hold_valid_next;
            r_hold_payload <= w_hold_payload_next;
        end
    end

endmodule

// File: rtl/data_collect_sched.sv
// -----------------------------------------------------------------------------
// data_collect_sched
//
// Sequencer and write arbiter for the 32x1024 data collection RAM. Owns the
// collection FSM (IDLE/ARMED/RUN/DONE), the buffer write address, written
// sample count, timestamp, feedback decimation and the sticky status flags.
// The RAM wrapper only needs buf_wen/buf_waddr/buf_wdata.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ctl_arm / ctl_stop         one-cycle control pulses (stop wins)
//   ctl_chan/count/decim       collection settings, latched on arm
//   cmd_req/chan/data          commanded-current samples from the host
//   fb_req/fb_data             feedback samples for the active channel
//   buf_wen/waddr/wdata        registered RAM write port
//   chan                       active channel (drives the feedback mux)
//   state                      IDLE=0, ARMED=1, RUN=2, DONE=3
//   wrapped                    sticky: the ring address wrapped
//   overrun                    sticky: a command sample was dropped
// -----------------------------------------------------------------------------
module data_collect_sched
    import data_collect_sched_pkg::*;
#(
    parameter int ADDR_W  = DCOL_ADDR_W,
    parameter int DECIM_W = DCOL_DECIM_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctl_arm,
    input  logic                   ctl_stop,
    input  logic [3:0]             ctl_chan,
    input  logic [ADDR_W-1:0]      ctl_count,
    input  logic [DECIM_W-1:0]     ctl_decim,
    input  logic                   cmd_req,
    input  logic [3:0]             cmd_chan,
    input  logic [15:0]            cmd_data,
    input  logic                   fb_req,
    input  logic [15:0]            fb_data,
    output logic                   buf_wen,
    output logic [ADDR_W-1:0]      buf_waddr,
    output logic [31:0]            buf_wdata,
    output logic [3:0]             chan,
    output logic [1:0]             state,
    output logic                   wrapped,
    output logic                   overrun
);

    localparam logic [ADDR_W-1:0]    L_ADDR_ONE  = ADDR_W'(1);
    localparam logic [DECIM_W-1:0]   L_DECIM_ONE = DECIM_W'(1);
    localparam logic [DCOL_TS_W-1:0] L_TS_ONE    = DCOL_TS_W'(1);

    // ---------------------------------------------------------------- state
    dcol_state_e                r_state;
    dcol_state_e                w_state_next;

    logic [DCOL_CHAN_W-1:0]     r_chan;
    logic [ADDR_W-1:0]          r_count;
    logic [DECIM_W-1:0]         r_decim;
    logic [DECIM_W-1:0]         r_decim_cnt;
    logic [DCOL_TS_W-1:0]       r_ts;
    logic [ADDR_W-1:0]          r_wcount;
    logic [ADDR_W-1:0]          r_addr_next;   // address the next write will use

    logic                       r_buf_wen;
    logic [ADDR_W-1:0]          r_buf_waddr;
    logic [DCOL_WORD_W-1:0]     r_buf_wdata;
    logic                       r_wrapped;
    logic                       r_overrun;

    // ---------------------------------------------------------------- decode
    logic w_armed;
    logic w_run;
    logic w_arm_take;
    logic w_cmd_match;
    logic w_trigger;
    logic w_cmd_valid;
    logic w_fb_seen;
    logic w_fb_take;
    logic w_write;
    logic w_limit_hit;
    logic w_flush;

    logic                      w_arb_valid;
    logic [DCOL_WORD_W-1:0]    w_arb_word;
    logic                      w_arb_overrun;
    logic [DCOL_PAYLOAD_W-1:0] w_cmd_payload;
    logic [DCOL_PAYLOAD_W-1:0] w_fb_payload;

    assign w_armed     = (r_state == DCOL_ARMED);
    assign w_run       = (r_state == DCOL_RUN);
    assign w_arm_take  = ctl_arm && !ctl_stop &&
                         ((r_state == DCOL_IDLE) || (r_state == DCOL_DONE));
    assign w_cmd_match = cmd_req && (cmd_chan == r_chan);

    // The first matching command while ARMED is the trigger; it goes through
    // the arbiter like any other command (hold is always empty here).
    assign w_trigger   = w_armed && w_cmd_match && !ctl_stop;
    assign w_cmd_valid = (w_armed || w_run) && w_cmd_match && !ctl_stop;

    // Decimation counter sees every feedback strobe in RUN; only strobes that
    // find it at zero are offered to the arbiter.
    assign w_fb_seen   = w_run && fb_req && !ctl_stop;
    assign w_fb_take   = w_fb_seen && (r_decim_cnt == '0);

    assign w_cmd_payload = {r_ts, r_chan, cmd_data};
    assign w_fb_payload  = {r_ts, r_chan, fb_data};

    // A held command granted in the stop cycle is not written.
    assign w_write     = w_arb_valid && !ctl_stop;
    assign w_limit_hit = w_write && (r_count != '0) &&
                         ((r_wcount + L_ADDR_ONE) == r_count);

    // Anything still parked is meaningless once collection ends.
    assign w_flush     = ctl_stop || w_limit_hit;

    dcol_arb u_arb (
        .clk           (clk),
        .reset         (reset),
        .i_flush       (w_flush),
        .i_cmd_valid   (w_cmd_valid),
        .i_cmd_payload (w_cmd_payload),
        .i_fb_valid    (w_fb_take),
        .i_fb_payload  (w_fb_payload),
        .o_wr_valid    (w_arb_valid),
        .o_wr_word     (w_arb_word),
        .o_overrun     (w_arb_overrun)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DCOL_IDLE,
            DCOL_DONE: begin
                if (ctl_arm) begin
                    w_state_next = DCOL_ARMED;
                end
            end
            DCOL_ARMED: begin
                // A limit of 1 is satisfied by the trigger write itself.
                if (w_trigger) begin
                    w_state_next = w_limit_hit ? DCOL_DONE : DCOL_RUN;
                end
            end
            DCOL_RUN: begin
                if (w_limit_hit) begin
                    w_state_next = DCOL_DONE;
                end
            end
            default: begin
                w_state_next = DCOL_IDLE;
            end
        endcase

        if (ctl_stop) begin
            w_state_next = DCOL_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DCOL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chan      <= DCOL_RESET_CHAN;
            r_count     <= '0;
            r_decim     <= '0;
            r_decim_cnt <= '0;
            r_ts        <= '0;
            r_wcount    <= '0;
            r_addr_next <= '0;
            r_buf_wen   <= 1'b0;
            r_buf_waddr <= '0;
            r_buf_wdata <= '0;
            r_wrapped   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_buf_wen <= w_write;

            if (w_write) begin
                r_buf_waddr <= r_addr_next;
                r_buf_wdata <= w_arb_word;
                r_addr_next <= r_addr_next + L_ADDR_ONE;
                r_wcount    <= r_wcount + L_ADDR_ONE;
                if (r_addr_next == '1) begin
                    r_wrapped <= 1'b1;
                end
            end

            if (w_arb_overrun) begin
                r_overrun <= 1'b1;
            end

            if (w_run) begin
                r_ts <= r_ts + L_TS_ONE;
            end

            if (w_fb_seen) begin
                r_decim_cnt <= (r_decim_cnt == '0) ? r_decim
                                                   : (r_decim_cnt - L_DECIM_ONE);
            end

            // Timestamp restarts at the trigger (it is already zero from arm,
            // but this keeps the intent explicit if ARMED ever counts).
            if (w_trigger) begin
                r_ts <= '0;
            end

            // Arm only happens in IDLE/DONE, where no write can be in flight,
            // so it never collides with the write updates above.
            if (w_arm_take) begin
                r_chan      <= ctl_chan;
                r_count     <= ctl_count;
                r_decim     <= ctl_decim;
                r_decim_cnt <= '0;
                r_ts        <= '0;
                r_wcount    <= '0;
                r_addr_next <= '0;
                r_buf_waddr <= '0;
                r_wrapped   <= 1'b0;
                r_overrun   <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign buf_wen   = r_buf_wen;
    assign buf_waddr = r_buf_waddr;
    assign buf_wdata = r_buf_wdata;
    assign chan      = r_chan;
    assign state     = r_state;
    assign wrapped   = r_wrapped;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_data_collect_sched.sv
module tb_data_collect_sched;

    localparam int ADDR_W  = 10;
    localparam int DECIM_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               ctl_arm;
    logic               ctl_stop;
    logic [3:0]         ctl_chan;
    logic [ADDR_W-1:0]  ctl_count;
    logic [DECIM_W-1:0] ctl_decim;
    logic               cmd_req;
    logic [3:0]         cmd_chan;
    logic [15:0]        cmd_data;
    logic               fb_req;
    logic [15:0]        fb_data;
    logic               buf_wen;
    logic [ADDR_W-1:0]  buf_waddr;
    logic [31:0]        buf_wdata;
    logic [3:0]         chan;
    logic [1:0]         state;
    logic               wrapped;
    logic               overrun;

    int n_vec = 0;
    int n_err = 0;
    bit quiet = 1'b0;

    always #5 clk = ~clk;

    data_collect_sched #(.ADDR_W(ADDR_W), .DECIM_W(DECIM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl_arm   (ctl_arm),
        .ctl_stop  (ctl_stop),
        .ctl_chan  (ctl_chan),
        .ctl_count (ctl_count),
        .ctl_decim (ctl_decim),
        .cmd_req   (cmd_req),
        .cmd_chan  (cmd_chan),
        .cmd_data  (cmd_data),
        .fb_req    (fb_req),
        .fb_data   (fb_data),
        .buf_wen   (buf_wen),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .chan      (chan),
        .state     (state),
        .wrapped   (wrapped),
        .overrun   (overrun)
    );

    // One line per RAM write transaction (suppressed during the long ring run).
    always @(posedge clk) begin
        #1;
        if (buf_wen === 1'b1 && !quiet)
            $display("[%0t] write addr=%0d data=%h state=%0d", $time, buf_waddr, buf_wdata, state);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [3:0] c, input logic [ADDR_W-1:0] n, input logic [DECIM_W-1:0] d);
        ctl_arm = 1'b1; ctl_chan = c; ctl_count = n; ctl_decim = d;
        cyc();
        ctl_arm = 1'b0;
    endtask

    // ------------------------------------------------------------------ reset
    task automatic test_reset();
        reset = 1'b1;
        ctl_arm = 0; ctl_stop = 0; ctl_chan = 0; ctl_count = 0; ctl_decim = 0;
        cmd_req = 0; cmd_chan = 0; cmd_data = 0; fb_req = 0; fb_data = 0;
        repeat (2) cyc();
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, chan, state, wrapped, overrun} !==
            {1'b0, 10'd0, 32'd0, 4'd1, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_held: wen=%b addr=%0d data=%h chan=%0d state=%0d wr=%b ov=%b, required 0/0/0/1/0/0/0",
                     buf_wen, buf_waddr, buf_wdata, chan, state, wrapped, overrun);
        end
        reset = 1'b0;
        repeat (2) cyc();
        n_vec++;
        if ({buf_wen, chan, state} !== {1'b0, 4'd1, 2'd0}) begin
            n_err++;
            $display("FAIL reset_release: wen=%b chan=%0d state=%0d, required 0/1/0", buf_wen, chan, state);
        end
    endtask

    // ------------------------------------------------- arm, trigger, limit
    task automatic test_arm_limit();
        arm(4'd3, 10'd4, 8'd0);
        n_vec++;
        if ({state, chan, buf_wen} !== {2'd1, 4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL arm: state=%0d chan=%0d wen=%b, required 1/3/0", state, chan, buf_wen);
        end
        // ARMED: feedback and non-matching command do nothing
        fb_req = 1; fb_data = 16'hDEAD; cmd_req = 1; cmd_chan = 4'd4; cmd_data = 16'h9999;
        cyc();
        fb_req = 0; cmd_req = 0;
        n_vec++;
        if ({buf_wen, state} !== {1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL armed_ignore: wen=%b state=%0d, required 0/1", buf_wen, state);
        end
        // trigger
        cmd_req = 1; cmd_chan = 4'd3; cmd_data = 16'h0100;
        cyc();
        cmd_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, state} !== {1'b1, 10'd0, 32'h40030100, 2'd2}) begin
            n_err++;
            $display("FAIL trigger_write: wen=%b addr=%0d data=%h state=%0d, required 1/0/40030100/2",
                     buf_wen, buf_waddr, buf_wdata, state);
        end
        // RUN cycle ts=0: feedback
        fb_req = 1; fb_data = 16'h1111; cyc(); fb_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata} !== {1'b1, 10'd1, 32'hC0031111}) begin
            n_err++;
            $display("FAIL fb1: wen=%b addr=%0d data=%h, required 1/1/C0031111", buf_wen, buf_waddr, buf_wdata);
        end
        cyc();  // ts=1
        n_vec++;
        if (buf_wen !== 1'b0) begin
            n_err++;
            $display("FAIL idle_gap: wen=%b, required 0", buf_wen);
        end
        fb_req = 1; fb_data = 16'h2222; cyc(); fb_req = 0;   // ts=2
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, state} !== {1'b1, 10'd2, 32'hC0232222, 2'd2}) begin
            n_err++;
            $display("FAIL fb2: wen=%b addr=%0d data=%h state=%0d, required 1/2/C0232222/2",
                     buf_wen, buf_waddr, buf_wdata, state);
        end
        cyc();  // ts=3
        fb_req = 1; fb_data = 16'h3333; cyc(); fb_req = 0;   // ts=4, 4th write
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, state} !== {1'b1, 10'd3, 32'hC0433333, 2'd3}) begin
            n_err++;
            $display("FAIL fb3_done: wen=%b addr=%0d data=%h state=%0d, required 1/3/C0433333/3",
                     buf_wen, buf_waddr, buf_wdata, state);
        end
        cyc();
        fb_req = 1; fb_data = 16'h4444; cmd_req = 1; cmd_chan = 4'd3; cmd_data = 16'h5555;
        cyc();
        fb_req = 0; cmd_req = 0;
        n_vec++;
        if ({buf_wen, state} !== {1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL after_done: wen=%b state=%0d, required 0/3", buf_wen, state);
        end
    endtask

    // ------------------------------------------------- limit of one (from DONE)
    task automatic test_limit_one();
        arm(4'd2, 10'd1, 8'd0);
        cmd_req = 1; cmd_chan = 4'd2; cmd_data = 16'hBEEF;
        cyc();
        cmd_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, state} !== {1'b1, 10'd0, 32'h4002BEEF, 2'd3}) begin
            n_err++;
            $display("FAIL limit_one: wen=%b addr=%0d data=%h state=%0d, required 1/0/4002BEEF/3",
                     buf_wen, buf_waddr, buf_wdata, state);
        end
    endtask

    // ------------------------------------------------- collision
    task automatic test_collision();
        arm(4'd5, 10'd0, 8'd0);
        cmd_req = 1; cmd_chan = 4'd5; cmd_data = 16'hAAAA;
        cyc();
        cmd_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, state} !== {1'b1, 10'd0, 32'h4005AAAA, 2'd2}) begin
            n_err++;
            $display("FAIL coll_trigger: wen=%b addr=%0d data=%h state=%0d, required 1/0/4005AAAA/2",
                     buf_wen, buf_waddr, buf_wdata, state);
        end
        // ts=0: command and feedback together
        cmd_req = 1; cmd_data = 16'hBBBB; fb_req = 1; fb_data = 16'hCCCC;
        cyc();
        cmd_req = 0; fb_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata} !== {1'b1, 10'd1, 32'hC005CCCC}) begin
            n_err++;
            $display("FAIL coll_fb_first: wen=%b addr=%0d data=%h, required 1/1/C005CCCC", buf_wen, buf_waddr, buf_wdata);
        end
        cyc();  // ts=1
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, overrun} !== {1'b1, 10'd2, 32'h8005BBBB, 1'b0}) begin
            n_err++;
            $display("FAIL coll_held: wen=%b addr=%0d data=%h ov=%b, required 1/2/8005BBBB/0",
                     buf_wen, buf_waddr, buf_wdata, overrun);
        end
        cyc();  // ts=2
        n_vec++;
        if (buf_wen !== 1'b0) begin
            n_err++;
            $display("FAIL coll_drain: wen=%b, required 0", buf_wen);
        end
    endtask

    // ------------------------------------------------- overrun (continues RUN, chan 5, ts=3)
    task automatic test_overrun();
        fb_req = 1; fb_data = 16'h1234; cmd_req = 1; cmd_chan = 4'd5; cmd_data = 16'h5678;
        cyc();  // ts=3
        fb_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata} !== {1'b1, 10'd3, 32'hC0351234}) begin
            n_err++;
            $display("FAIL ovr_fb: wen=%b addr=%0d data=%h, required 1/3/C0351234", buf_wen, buf_waddr, buf_wdata);
        end
        cmd_data = 16'h9ABC;
        cyc();  // ts=4: held 5678 written, 9ABC dropped
        cmd_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, overrun} !== {1'b1, 10'd4, 32'h80355678, 1'b1}) begin
            n_err++;
            $display("FAIL ovr_held: wen=%b addr=%0d data=%h ov=%b, required 1/4/80355678/1",
                     buf_wen, buf_waddr, buf_wdata, overrun);
        end
        cyc();  // ts=5
        n_vec++;
        if (buf_wen !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_dropped: wen=%b, required 0", buf_wen);
        end
        cmd_req = 1; cmd_chan = 4'd2; cmd_data = 16'h1111;
        cyc();  // ts=6
        cmd_req = 0;
        n_vec++;
        if (buf_wen !== 1'b0) begin
            n_err++;
            $display("FAIL other_chan: wen=%b, required 0", buf_wen);
        end
        arm(4'd9, 10'd7, 8'd3);  // ts=7, ignored in RUN
        n_vec++;
        if ({state, chan} !== {2'd2, 4'd5}) begin
            n_err++;
            $display("FAIL arm_in_run: state=%0d chan=%0d, required 2/5", state, chan);
        end
        cmd_req = 1; cmd_chan = 4'd5; cmd_data = 16'h4242;
        cyc();  // ts=8
        cmd_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata} !== {1'b1, 10'd5, 32'h40854242}) begin
            n_err++;
            $display("FAIL direct_cmd: wen=%b addr=%0d data=%h, required 1/5/40854242", buf_wen, buf_waddr, buf_wdata);
        end
    endtask

    // ------------------------------------------------- stop (continues RUN, ts=9)
    task automatic test_stop();
        cmd_req = 1; cmd_chan = 4'd5; cmd_data = 16'h1357; fb_req = 1; fb_data = 16'h2468;
        cyc();  // fb written, 1357 held
        fb_req = 0;
        // stop cycle: previous write still presented, new command arrives with stop
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata} !== {1'b1, 10'd6, 32'hC0952468}) begin
            n_err++;
            $display("FAIL stop_prev_write: wen=%b addr=%0d data=%h, required 1/6/C0952468", buf_wen, buf_waddr, buf_wdata);
        end
        ctl_stop = 1; cmd_data = 16'hFFFF;
        cyc();
        ctl_stop = 0; cmd_req = 0;
        n_vec++;
        if ({buf_wen, state} !== {1'b0, 2'd0}) begin
            n_err++;
            $display("FAIL stop: wen=%b state=%0d, required 0/0", buf_wen, state);
        end
        cyc();
        n_vec++;
        if ({buf_wen, state, overrun} !== {1'b0, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL stop_hold_flushed: wen=%b state=%0d ov=%b, required 0/0/1", buf_wen, state, overrun);
        end
    endtask

    // ------------------------------------------------- decimation and ring
    task automatic test_decim_ring();
        int writes;
        logic [ADDR_W-1:0] last_addr;
        writes = 0;
        last_addr = '0;
        quiet = 1'b1;
        arm(4'd7, 10'd0, 8'd2);
        n_vec++;
        if ({wrapped, overrun, buf_waddr, state} !== {1'b0, 1'b0, 10'd0, 2'd1}) begin
            n_err++;
            $display("FAIL ring_arm_clear: wr=%b ov=%b addr=%0d state=%0d, required 0/0/0/1",
                     wrapped, overrun, buf_waddr, state);
        end
        // pulse 0 coincides with the trigger and is ignored (ARMED)
        cmd_req = 1; cmd_chan = 4'd7; cmd_data = 16'h0000; fb_req = 1; fb_data = 16'h0000;
        cyc();
        cmd_req = 0; fb_req = 0;
        if (buf_wen === 1'b1) begin writes++; last_addr = buf_waddr; end
        for (int i = 1; i < 3100; i++) begin
            fb_req = 1; fb_data = 16'(i);
            cyc();
            fb_req = 0;
            if (buf_wen === 1'b1) begin writes++; last_addr = buf_waddr; end
            cyc();
            if (buf_wen === 1'b1) begin writes++; last_addr = buf_waddr; end
        end
        quiet = 1'b0;
        $display("[%0t] ring run: %0d writes, last addr %0d, wrapped %b", $time, writes, last_addr, wrapped);
        n_vec++;
        if (writes != 1034) begin
            n_err++;
            $display("FAIL ring_writes: got %0d, required 1034", writes);
        end
        n_vec++;
        if ({wrapped, last_addr, buf_waddr, state} !== {1'b1, 10'd9, 10'd9, 2'd2}) begin
            n_err++;
            $display("FAIL ring_wrap: wr=%b last=%0d addr=%0d state=%0d, required 1/9/9/2",
                     wrapped, last_addr, buf_waddr, state);
        end
        n_vec++;
        if ({buf_wdata[31:30], buf_wdata[19:16], buf_wdata[15:0]} !== {2'b11, 4'd7, 16'd3097}) begin
            n_err++;
            $display("FAIL ring_last_word: data=%h, required tag 11 chan 7 sample 3097", buf_wdata);
        end
    endtask

    // ------------------------------------------------- async reset mid-run
    task automatic test_reset_midrun();
        fb_req = 1; fb_data = 16'h5555;
        cyc();
        fb_req = 0;
        n_vec++;
        if ({buf_wen, buf_waddr, state, wrapped} !== {1'b1, 10'd10, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset: wen=%b addr=%0d state=%0d wr=%b, required 1/10/2/1",
                     buf_wen, buf_waddr, state, wrapped);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({buf_wen, buf_waddr, buf_wdata, chan, state, wrapped, overrun} !==
            {1'b0, 10'd0, 32'd0, 4'd1, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: wen=%b addr=%0d data=%h chan=%0d state=%0d wr=%b ov=%b, required 0/0/0/1/0/0/0",
                     buf_wen, buf_waddr, buf_wdata, chan, state, wrapped, overrun);
        end
        #1;
        reset = 1'b0;
        cyc();
        n_vec++;
        if ({buf_wen, state, chan} !== {1'b0, 2'd0, 4'd1}) begin
            n_err++;
            $display("FAIL post_reset: wen=%b state=%0d chan=%0d, required 0/0/1", buf_wen, state, chan);
        end
    endtask

    initial begin
        test_reset();
        test_arm_limit();
        test_limit_one();
        test_collision();
        test_overrun();
        test_stop();
        test_decim_ring();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
